instr_rom: RTL and testbench

//  Instruction-memory responder serving the fetch stage: word-addressed BRAM

---
 rtl/instr_rom.sv | 128 ++++++++++++
 tb/tb_instr_rom.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/instr_rom.sv
// Instruction memory for the fetch stage: registered word read, plus a byte-stream
// program loader that fills the memory before execution starts.
module instr_rom #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] rom_addr,
  output logic [31:0] rom_data,
  input  logic        load_start,
  input  logic        load_valid,
  input  logic [7:0]  load_byte,
  output logic        load_busy,
  output logic        load_done,
  output logic        load_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, LEN, DATA, DONE} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              byte_cnt_q, byte_cnt_d;
  logic [31:0]             word_cnt_q, word_cnt_d;
  logic [31:0]             len_q, len_d;
  logic [31:0]             sr_q, sr_d;
  logic                    busy_d, done_d, err_d;
  logic                    we_c;
  logic [ADDR_WIDTH-1:0]   waddr_c;
  logic [ADDR_WIDTH-1:0]   raddr_c;
  logic [31:0]             asm_c;
  logic                    unused_addr_c;

  logic [31:0] mem [DEPTH];

  // Little-endian assembly: each new byte enters at the top, first byte ends at [7:0]
  assign asm_c         = {load_byte, sr_q[31:8]};
  assign waddr_c       = word_cnt_q[ADDR_WIDTH-1:0];
  assign raddr_c       = rom_addr[ADDR_WIDTH+1:2];
  assign unused_addr_c = ^{rom_addr[31:ADDR_WIDTH+2], rom_addr[1:0]};

  // Loader next-state and flag logic
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    sr_d       = sr_q;
    done_d     = load_done;
    err_d      = load_err;
    we_c       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d    = LEN;
          byte_cnt_d = 2'd0;
          word_cnt_d = 32'd0;
          len_d      = 32'd0;
          done_d     = 1'b0;
          err_d      = 1'b0;
        end
      end
      LEN: begin
        if (load_valid) begin
          sr_d       = asm_c;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            len_d   = asm_c;
            state_d = (asm_c == 32'd0) ? DONE : DATA;
          end
        end
      end
      DATA: begin
        if (load_valid) begin
          sr_d       = asm_c;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Words past the end of memory are consumed but dropped
            if (word_cnt_q[31:ADDR_WIDTH] == '0) we_c = 1'b1;
            else                                 err_d = 1'b1;
            if (word_cnt_q == len_q - 32'd1) state_d = DONE;
            else                             word_cnt_d = word_cnt_q + 32'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == LEN) || (state_d == DATA);
    if (state_d == DONE) done_d = 1'b1;
  end

  // State, counters, flags and read data
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      byte_cnt_q <= 2'd0;
      word_cnt_q <= 32'd0;
      len_q      <= 32'd0;
      sr_q       <= 32'd0;
      load_busy  <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      rom_data   <= 32'd0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      sr_q       <= sr_d;
      load_busy  <= busy_d;
      load_done  <= done_d;
      load_err   <= err_d;
      rom_data   <= busy_d ? NOP : mem[raddr_c];
    end
  end

  // Memory array has no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (we_c) mem[waddr_c] <= asm_c;
  end

endmodule

// File: tb/tb_instr_rom.sv
// Self-checking bench for instr_rom: randomized program loads checked against an
// array model of memory contents and loader flags.
module tb_instr_rom;

  typedef logic [31:0] word_q_t[$];
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] rom_addr = 32'd0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = 8'd0;
  logic        start12 = 1'b0, start2 = 1'b0;
  logic [31:0] data12, data2;
  logic        busy12, done12, err12, busy2, done2, err2;

  always #5 clk = ~clk;

  instr_rom #(.ADDR_WIDTH(12)) u12 (
    .clk(clk), .rstn(rstn), .rom_addr(rom_addr), .rom_data(data12),
    .load_start(start12), .load_valid(load_valid), .load_byte(load_byte),
    .load_busy(busy12), .load_done(done12), .load_err(err12));

  instr_rom #(.ADDR_WIDTH(2)) u2 (
    .clk(clk), .rstn(rstn), .rom_addr(rom_addr), .rom_data(data2),
    .load_start(start2), .load_valid(load_valid), .load_byte(load_byte),
    .load_busy(busy2), .load_done(done2), .load_err(err2));

  logic [31:0] ref12 [4096];
  logic [31:0] ref2  [4];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  function automatic logic [31:0] obs(input bit which, input int what);
    case (what)
      0:       return which ? data2 : data12;
      1:       return which ? {31'd0, busy2} : {31'd0, busy12};
      2:       return which ? {31'd0, done2} : {31'd0, done12};
      default: return which ? {31'd0, err2}  : {31'd0, err12};
    endcase
  endfunction

  task automatic pulse_start(input bit which);
    if (which) start2 = 1'b1; else start12 = 1'b1;
    @(negedge clk);
    start2  = 1'b0;
    start12 = 1'b0;
  endtask

  // Streams header + words; optionally aborts with reset before byte abort_at
  task automatic do_load(input bit which, input word_q_t words, input int max_idle,
                         input int abort_at, input bit poke);
    logic [7:0]  bytes[$];
    logic [31:0] n;
    bit          err_exp;
    int          depth;
    n       = 32'(words.size());
    depth   = which ? 4 : 4096;
    err_exp = 1'b0;
    for (int i = 0; i < 4; i++) bytes.push_back(8'(n >> (8 * i)));
    foreach (words[k]) for (int i = 0; i < 4; i++) bytes.push_back(8'(words[k] >> (8 * i)));
    @(negedge clk);
    pulse_start(which);
    for (int j = 0; j < bytes.size(); j++) begin
      int idle = (max_idle > 0) ? int'($urandom_range(max_idle, 0)) : 0;
      if (j == abort_at) begin
        #2 rstn = 1'b0;
        #1;
        chk("abort_data", obs(which, 0), 32'd0);
        chk("abort_busy", obs(which, 1), 32'd0);
        chk("abort_done", obs(which, 2), 32'd0);
        chk("abort_err",  obs(which, 3), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        return;
      end
      if (poke && j == 5) begin
        chk("poke_busy", obs(which, 1), 32'd1);
        pulse_start(which);
      end
      repeat (idle) begin
        chk("idle_busy", obs(which, 1), 32'd1);
        chk("idle_nop",  obs(which, 0), NOP);
        @(negedge clk);
      end
      chk("busy", obs(which, 1), 32'd1);
      chk("nop",  obs(which, 0), NOP);
      load_valid = 1'b1;
      load_byte  = bytes[j];
      @(negedge clk);
      load_valid = 1'b0;
      load_byte  = 8'($urandom);
      if (j >= 4 && (j - 4) % 4 == 3) begin
        int i = (j - 4) / 4;
        if (i >= depth)   err_exp = 1'b1;
        else if (which)   ref2[i]  = words[i];
        else              ref12[i] = words[i];
      end
    end
    @(negedge clk);
    chk("end_busy", obs(which, 1), 32'd0);
    chk("end_done", obs(which, 2), 32'd1);
    chk("end_err",  obs(which, 3), {31'd0, err_exp});
  endtask

  task automatic rd_at(input bit which, input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    rom_addr = addr;
    @(negedge clk);
    @(negedge clk);
    chk("read", obs(which, 0), exp);
  endtask

  // Random upper and lower address bits must not affect the word selected
  task automatic rd_rand(input bit which, input int idx);
    logic [31:0] mask, a;
    mask = which ? 32'd3 : 32'hFFF;
    a    = ($urandom & ~(mask << 2)) | (32'(idx) << 2);
    rd_at(which, a, which ? ref2[idx] : ref12[idx]);
  endtask

  initial begin
    word_q_t w;
    repeat (3) @(negedge clk);
    chk("rst_data", data12, 32'd0);
    chk("rst_busy", {31'd0, busy12}, 32'd0);
    chk("rst_done", {31'd0, done12}, 32'd0);
    chk("rst_err",  {31'd0, err2}, 32'd0);
    rstn = 1'b1;

    w = {32'h00a00513, 32'h010002b7};
    do_load(1'b0, w, 0, -1, 1'b0);
    rd_at(1'b0, 32'd4, 32'h010002b7);
    rd_at(1'b0, 32'd6, 32'h010002b7);
    rd_at(1'b0, 32'd0, 32'h00a00513);

    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_data", data12, 32'd0);
    chk("mid_rst_busy", {31'd0, busy12}, 32'd0);
    chk("mid_rst_done", {31'd0, done12}, 32'd0);
    chk("mid_rst_err",  {31'd0, err12}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    rd_at(1'b0, 32'd4, 32'h010002b7);

    w = {};
    do_load(1'b0, w, 0, -1, 1'b0);
    rd_at(1'b0, 32'd0, 32'h00a00513);

    w = {32'h00a00513, 32'h010002b7};
    do_load(1'b0, w, 5, -1, 1'b0);
    rd_at(1'b0, 32'd0, 32'h00a00513);
    rd_at(1'b0, 32'd4, 32'h010002b7);

    for (int it = 0; it < 6; it++) begin
      int n = int'($urandom_range(8, 2));
      w = {};
      for (int i = 0; i < n; i++) w.push_back($urandom);
      do_load(1'b0, w, int'($urandom_range(3, 0)), -1, it == 2);
      for (int i = 0; i < n; i++) rd_rand(1'b0, i);
    end

    w = {$urandom, $urandom, $urandom};
    do_load(1'b0, w, 1, 6, 1'b0);
    @(negedge clk);
    chk("post_abort_busy", {31'd0, busy12}, 32'd0);
    rd_rand(1'b0, 0);
    w = {$urandom, $urandom, $urandom};
    do_load(1'b0, w, 2, -1, 1'b0);
    for (int i = 0; i < 3; i++) rd_rand(1'b0, i);

    w = {$urandom, $urandom, $urandom, $urandom, $urandom};
    do_load(1'b1, w, 1, -1, 1'b0);
    for (int i = 0; i < 4; i++) rd_rand(1'b1, i);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
